// File: rtl/capture_sender_of_verifla.sv
// capture_sender_of_verifla: streams every capture-memory word to the UART TX, MSB byte first,
// under the sc_run/ack_sc_run/sc_done handshake with the capture monitor.
module capture_sender_of_verifla #(
   parameter int LA_MEM_ADDRESS_BITS = 8,
   parameter int LA_MEM_WORDLEN_BITS = 24,
   parameter int LA_MEM_LAST_ADDR    = 255,
   parameter int WORD_BYTES          = (LA_MEM_WORDLEN_BITS + 7) / 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           sc_run,
   output logic                           ack_sc_run,
   output logic                           sc_done,
   output logic [LA_MEM_ADDRESS_BITS-1:0] mem_port_B_address,
   input  logic [LA_MEM_WORDLEN_BITS-1:0] mem_port_B_dout,
   output logic [7:0]                     tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready
);
   localparam int WB = WORD_BYTES * 8;
   localparam int IW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ACK     = 3'd1;
   localparam logic [2:0] ST_RD_ADDR = 3'd2;
   localparam logic [2:0] ST_RD_WAIT = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   logic [2:0]                     state_q, state_d;
   logic [LA_MEM_ADDRESS_BITS-1:0] cnt_q, cnt_d;
   logic [LA_MEM_ADDRESS_BITS-1:0] addr_q, addr_d;
   logic [IW-1:0]                  idx_q, idx_d;
   logic [WB-1:0]                  word_q, word_d;
   logic                           last_byte, last_addr;
   assign last_byte = idx_q == IW'(WORD_BYTES - 1);
   assign last_addr = cnt_q == LA_MEM_ADDRESS_BITS'(LA_MEM_LAST_ADDR);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      word_d  = word_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d   = '0;
            state_d = sc_run ? ST_ACK : ST_IDLE;
         end
         ST_ACK: state_d = ST_RD_ADDR;
         ST_RD_ADDR: begin
            addr_d  = cnt_q;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            word_d  = WB'(mem_port_B_dout);
            idx_d   = '0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (tx_ready) begin
               if (!last_byte) idx_d = idx_q + 1'b1;
               else if (last_addr) state_d = ST_DONE;
               else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = ST_RD_ADDR;
               end
            end
         end
         ST_DONE: state_d = sc_run ? ST_DONE : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
      end
   end
   // Address is presented straight from the counter in RD_ADDR so data arrives in RD_WAIT.
   assign mem_port_B_address = state_q == ST_RD_ADDR ? cnt_q : addr_q;
   assign ack_sc_run = state_q == ST_ACK;
   assign sc_done    = state_q == ST_DONE;
   assign tx_valid   = state_q == ST_SEND;
   assign tx_data    = word_q[8 * (WORD_BYTES - 1 - int'(idx_q)) +: 8];
endmodule

// File: tb/tb_capture_sender_of_verifla.sv
// tb_capture_sender_of_verifla: directed/random dumps of two parameterisations checked against
// a byte-stream reference built from the memory contents.
module tb_capture_sender_of_verifla;
   logic clk = 0, rst = 1, sc_run = 0, tx_ready = 1;
   logic ack, done, tx_valid;
   logic [7:0]  tx_data, addr;
   logic [23:0] dout;
   logic [23:0] mem [0:3];
   logic p_run = 0, p_ready = 1;
   logic p_ack, p_done, p_valid;
   logic [7:0]  p_data, p_addr;
   logic [19:0] p_dout;
   logic [19:0] pmem [0:1];
   logic [7:0] rx[$], prx[$], exp_q[$];
   int errors = 0, checks = 0, acks = 0, mode = 0, stall = 0;
   logic pv = 0, pr = 0;
   logic [7:0] pd = 0;
   always #5 clk = ~clk;
   capture_sender_of_verifla #(.LA_MEM_ADDRESS_BITS(8), .LA_MEM_WORDLEN_BITS(24), .LA_MEM_LAST_ADDR(3)) u_dut (
      .clk(clk), .rst(rst), .sc_run(sc_run), .ack_sc_run(ack), .sc_done(done),
      .mem_port_B_address(addr), .mem_port_B_dout(dout),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready));
   capture_sender_of_verifla #(.LA_MEM_ADDRESS_BITS(8), .LA_MEM_WORDLEN_BITS(20), .LA_MEM_LAST_ADDR(1)) u_pad (
      .clk(clk), .rst(rst), .sc_run(p_run), .ack_sc_run(p_ack), .sc_done(p_done),
      .mem_port_B_address(p_addr), .mem_port_B_dout(p_dout),
      .tx_data(p_data), .tx_valid(p_valid), .tx_ready(p_ready));
   always @(posedge clk) dout <= mem[addr[1:0]];
   always @(posedge clk) p_dout <= pmem[p_addr[0]];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Backpressure source: always ready, or toggling with occasional long stalls.
   initial forever begin
      @(posedge clk); #1;
      if (mode == 0) tx_ready = 1;
      else if (stall > 0) begin
         tx_ready = 0;
         stall--;
      end else begin
         tx_ready = ~tx_ready;
         if ($urandom_range(0, 9) == 0) stall = $urandom_range(1, 20);
      end
   end
   always @(negedge clk) begin
      if (!rst) begin
         if (pv && !pr) begin
            chk("hold_valid", tx_valid, 1);
            chk("hold_data", tx_data, pd);
         end
         if (tx_valid && tx_ready) rx.push_back(tx_data);
         if (p_valid && p_ready) prx.push_back(p_data);
         if (ack) acks++;
      end
      pv = tx_valid & ~rst;
      pr = tx_ready;
      pd = tx_data;
   end
   task automatic build_exp();
      exp_q.delete();
      for (int a = 0; a < 4; a++)
         for (int b = 2; b >= 0; b--) exp_q.push_back(8'((mem[a] >> (8 * b)) & 24'hFF));
   endtask
   task automatic run_dump(input bit hold);
      int n;
      build_exp();
      rx.delete();
      acks = 0;
      @(posedge clk); #1 sc_run = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!ack && n < 100);
      chk("ack_seen", ack, 1);
      @(posedge clk); #1;
      if (!hold) sc_run = 0;
      @(negedge clk);
      chk("ack_pulse", ack, 0);
      n = 0;
      while (!done && n < 3000) begin @(negedge clk); n++; end
      chk("done_seen", done, 1);
      chk("bytes_at_done", rx.size(), 12);
      for (int i = 0; i < 12 && i < rx.size(); i++) chk($sformatf("byte%0d", i), rx[i], exp_q[i]);
      chk("addr_hold", addr, 3);
      chk("ack_count", acks, 1);
      if (hold) begin
         repeat (10) @(negedge clk);
         chk("done_held", done, 1);
         chk("no_restart_ack", acks, 1);
         chk("no_restart_bytes", rx.size(), 12);
         @(posedge clk); #1 sc_run = 0;
         @(negedge clk);
         chk("done_after_drop", done, 1);
      end
      @(negedge clk);
      chk("done_low", done, 0);
   endtask
   initial begin
      int n;
      for (int i = 0; i < 4; i++) mem[i] = 24'h010000 + 24'(i);
      pmem[0] = 20'hABCDE;
      pmem[1] = 20'($urandom);
      repeat (3) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_addr", addr, 0);
      @(posedge clk); #1 rst = 0;
      repeat (5) @(negedge clk);
      chk("idle_valid", tx_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_acks", acks, 0);
      run_dump(0);
      run_dump(1);
      mode = 1;
      for (int i = 0; i < 4; i++) mem[i] = 24'($urandom);
      run_dump(0);
      mode = 0;
      @(posedge clk); #1 sc_run = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!ack && n < 100);
      @(posedge clk); #1 sc_run = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!(tx_valid && addr == 1) && n < 200);
      chk("pre_rst_valid", tx_valid, 1);
      #2 rst = 1;
      #1;
      chk("mid_rst_valid", tx_valid, 0);
      chk("mid_rst_ack", ack, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_data", tx_data, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      repeat (5) @(negedge clk);
      chk("post_rst_valid", tx_valid, 0);
      chk("post_rst_done", done, 0);
      for (int i = 0; i < 4; i++) mem[i] = 24'($urandom);
      run_dump(0);
      for (int i = 0; i < 4; i++) mem[i] = 24'($urandom);
      run_dump(0);
      prx.delete();
      @(posedge clk); #1 p_run = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!p_ack && n < 100);
      @(posedge clk); #1 p_run = 0;
      n = 0;
      while (!p_done && n < 1000) begin @(negedge clk); n++; end
      chk("pad_done", p_done, 1);
      chk("pad_count", prx.size(), 6);
      exp_q.delete();
      for (int a = 0; a < 2; a++)
         for (int b = 2; b >= 0; b--) exp_q.push_back(8'((24'(pmem[a]) >> (8 * b)) & 24'hFF));
      for (int i = 0; i < 6 && i < prx.size(); i++) chk($sformatf("pad_byte%0d", i), prx[i], exp_q[i]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
